// File: rtl/seqdet_pkg.sv
// Shared types and sizing helpers for the programmable sequence detector.
package seqdet_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } seqdet_state_e;

    // Fill counter must be able to hold the value PAT_W.
    function automatic int fill_cnt_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_shreg.sv
// Valid-qualified serial-in shift register with synchronous clear.
// window_next_o is the window as it will look once the current bit is shifted in.
module seqdet_shreg #(
    parameter int PAT_W = 8
) (
    input  logic             Clk,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             x_i,
    output logic [PAT_W-1:0] window_next_o
);

    logic [PAT_W-1:0] shreg_q;
    logic [PAT_W-1:0] shreg_d;

    assign window_next_o = {shreg_q[PAT_W-2:0], x_i};

    // Next shift register contents: clear wins over shift.
    always_comb begin
        shreg_d = shreg_q;
        if (clr_i) begin
            shreg_d = '0;
        end else if (shift_i) begin
            shreg_d = window_next_o;
        end
    end

    // Shift register state.
    always_ff @(posedge Clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/seqdet_prog.sv
// Programmable serial pattern detector: loadable pattern/mask, optional
// overlapping detection, input-valid qualifier and saturating match counter.
//
//   state    | meaning
//   ST_FILL  | collecting PAT_W fresh valid bits since reset, re-arm or (non-overlap) match
//   ST_ARMED | window holds PAT_W valid bits; every valid bit is compared
module seqdet_prog
    import seqdet_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(8'hCD),
    parameter int               CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FCW = fill_cnt_w(PAT_W);
    localparam logic [FCW-1:0] FILL_LAST = FCW'(PAT_W - 1);

    seqdet_state_e    state_q, state_d;
    logic [FCW-1:0]   fill_q, fill_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] pattern_q, mask_q;
    logic             overlap_q;
    logic [PAT_W-1:0] window_next;
    logic             match;

    seqdet_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .Clk           (Clk),
        .clr_i         (!rst_n || cfg_we),
        .shift_i       (x_valid),
        .x_i           (x),
        .window_next_o (window_next)
    );

    assign match = ((window_next ^ pattern_q) & mask_q) == '0;

    // Next-state, match pulse and counter update; re-arm beats an incoming bit.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        y_d     = 1'b0;
        cnt_d   = cnt_q;
        if (cfg_we) begin
            state_d = ST_FILL;
            fill_d  = '0;
        end else if (x_valid) begin
            if (state_q == ST_FILL) begin
                fill_d = fill_q + FCW'(1);
                if (fill_q == FILL_LAST) begin
                    state_d = ST_ARMED;
                    y_d     = match;
                end
            end else begin
                y_d = match;
            end
            // Non-overlapping: the shift register is kept, the window restarts via the fill count.
            if (y_d && !overlap_q) begin
                state_d = ST_FILL;
                fill_d  = '0;
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (y_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM, pulse and counter registers.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            y_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Runtime configuration registers.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            pattern_q <= PAT_DEFAULT;
            mask_q    <= '1;
            overlap_q <= 1'b1;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            mask_q    <= cfg_mask;
            overlap_q <= cfg_overlap;
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seqdet_prog.sv
// Randomised and directed bench for seqdet_prog against a bit-history model.
module tb_seqdet_prog;

    localparam int PAT_W = 8;

    logic             Clk = 1'b0;
    logic             rst_n;
    logic             x_valid;
    logic             x;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             y1, armed1, y2, armed2;
    logic [15:0]      cnt1;
    logic [1:0]       cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit          hist[$];
    int          m_n;
    logic [7:0]  m_pat, m_mask;
    logic        m_ov;
    logic        m_y;
    int          m_cnt, m_cnt2;

    always #5 Clk = ~Clk;

    seqdet_prog #(.PAT_W(PAT_W), .PAT_DEFAULT(8'hCD), .CNT_W(16)) dut (
        .Clk(Clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y1), .match_cnt(cnt1), .armed(armed1)
    );

    seqdet_prog #(.PAT_W(PAT_W), .PAT_DEFAULT(8'hCD), .CNT_W(2)) dut_sat (
        .Clk(Clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y2), .match_cnt(cnt2), .armed(armed2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a match is the last PAT_W valid bits agreeing with the pattern on
    // masked positions, once at least PAT_W fresh valid bits have been seen.
    task automatic model_edge();
        bit hit;
        if (!rst_n) begin
            m_pat = 8'hCD; m_mask = 8'hFF; m_ov = 1'b1;
            hist.delete(); m_n = 0; m_y = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_y = 1'b0;
            if (cfg_we) begin
                m_pat = cfg_pattern; m_mask = cfg_mask; m_ov = cfg_overlap;
                hist.delete(); m_n = 0;
            end else if (x_valid) begin
                hist.push_back(x);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                m_n++;
                if (m_n >= PAT_W) begin
                    hit = 1'b1;
                    for (int i = 0; i < PAT_W; i++)
                        if (m_mask[PAT_W-1-i] && (hist[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
                    if (hit) begin
                        m_y = 1'b1;
                        if (!m_ov) m_n = 0;
                    end
                end
            end
            if (cnt_clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (m_y) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        chk("y", y1, m_y);
        chk("armed", armed1, (m_n >= PAT_W));
        chk("match_cnt", cnt1, m_cnt);
        chk("y_sat", y2, m_y);
        chk("match_cnt_sat", cnt2, m_cnt2);
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; x_valid = 1'b0; x = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic send_bit(input logic v, input logic b);
        idle_inputs();
        x_valid = v; x = b;
        step();
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(1'b1, bits[i]);
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [7:0] m, input logic ov);
        idle_inputs();
        cfg_we = 1'b1; cfg_pattern = p; cfg_mask = m; cfg_overlap = ov; cnt_clr = 1'b1;
        step();
        cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        logic [23:0] s1;
        idle_inputs();
        cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0;

        // reset
        rst_n = 1'b0;
        step();
        step();
        chk("rst_y", y1, 0);
        chk("rst_armed", armed1, 0);
        chk("rst_cnt", cnt1, 0);

        // 1: default pattern in a rotating 24-bit stream
        s1 = 24'hCD1240;
        for (int r = 0; r < 3; r++) begin
            for (int i = 23; i >= 0; i--) begin
                send_bit(1'b1, s1[i]);
                if (r == 0 && i == 16) chk("t1_first_y", y1, 1);
                if (r == 0 && i == 17) chk("t1_no_early_y", y1, 0);
            end
        end
        chk("t1_cnt", cnt1, 3);

        // 2: overlapping 8'hAA
        do_cfg(8'hAA, 8'hFF, 1'b1);
        send_bits(32'h0000AAAA, 16);
        chk("t2_cnt", cnt1, 5);

        // 3: non-overlapping 8'hAA
        do_cfg(8'hAA, 8'hFF, 1'b0);
        send_bits(32'h0000AAAA, 16);
        chk("t3_cnt", cnt1, 2);

        // 4: masked pattern with x_valid toggling
        do_cfg(8'hF0, 8'hF0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] s4;
            s4 = 8'b1111_0101;
            send_bit(1'b1, s4[i]);
            if (i == 0) chk("t4_match", y1, 1);
            send_bit(1'b0, $urandom_range(0, 1));
            chk("t4_invalid_y", y1, 0);
        end
        chk("t4_cnt", cnt1, 1);

        // 5a: re-arm coincident with the completing bit
        do_cfg(8'hAA, 8'hFF, 1'b1);
        send_bits(32'h55, 7);
        idle_inputs();
        x_valid = 1'b1; x = 1'b0; cfg_we = 1'b1;
        step();
        chk("t5_cfg_y", y1, 0);
        chk("t5_cfg_armed", armed1, 0);
        // 5b: counter clear coincident with a match
        send_bits(32'h55, 7);
        idle_inputs();
        x_valid = 1'b1; x = 1'b0; cnt_clr = 1'b1;
        step();
        chk("t5_clr_y", y1, 1);
        chk("t5_clr_cnt", cnt1, 0);
        // 5c: saturation of the 2-bit counter
        send_bits(32'h2AA, 10);
        chk("t5_cnt16", cnt1, 5);
        chk("t5_cnt2_sat", cnt2, 3);

        // 6: reset mid-pattern
        do_cfg(8'hAA, 8'hFF, 1'b1);
        send_bits(32'h66, 7);
        idle_inputs();
        rst_n = 1'b0; x_valid = 1'b1; x = 1'b1;
        step();
        chk("t6_rst_y", y1, 0);
        chk("t6_rst_armed", armed1, 0);
        send_bit(1'b1, 1'b1);
        chk("t6_partial_y", y1, 0);
        send_bits(32'hCD, 8);
        chk("t6_full_y", y1, 1);

        // random phase
        for (int k = 0; k < 4000; k++) begin
            idle_inputs();
            x_valid = ($urandom_range(0, 3) != 0);
            x       = $urandom_range(0, 1);
            cnt_clr = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 50) == 0) begin
                cfg_we      = 1'b1;
                cfg_pattern = 8'($urandom);
                cfg_mask    = 8'($urandom & $urandom);
                cfg_overlap = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 300) == 0) rst_n = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
